ex_muldiv_iter: RTL and testbench
=================================

Name: ex_muldiv_iter

Overview:
- Multi-cycle multiply/divide unit beside the EX stage. Executes MULT, MULTU, DIV and DIVU on WIDTH-bit operands and produces the HI/LO pair.
- Successor to the single-cycle combinational multiply. Parametrised in width, adds signed and unsigned division, and uses a stall/cancel handshake with the pipeline.
- Results feed the same HI/LO write path (write enable plus HI and LO data) as the existing EX outputs.

Parameters:
- WIDTH, 32: operand width. HI and LO are each WIDTH bits. Must be ≥4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width. Derived from WIDTH; do not override.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start_i  in  1  request from EX. Held high by EX while the instruction sits stalled.
- op_i  in  2  operation, sampled with start_i: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- opa_i  in  WIDTH  rs: multiplicand or dividend
- opb_i  in  WIDTH  rt: multiplier or divisor
- cancel_i  in  1  pipeline flush; abort any operation in progress
- stall_o  out  1  stall request to pipeline control
- done_o  out  1  one-cycle pulse; results valid
- wrn_hilo_o  out  1  HI/LO write enable; equals done_o
- hi_o  out  WIDTH  product high half, or remainder
- lo_o  out  WIDTH  product low half, or quotient
- dbz_o  out  1  divide-by-zero flag; valid while done_o=1

Behaviour:
- States: IDLE, CALC, DONE. On rst: state IDLE, counter 0, internal registers 0.
- Output values on rst: done_o=0, wrn_hilo_o=0, hi_o=0, lo_o=0, dbz_o=0, stall_o=0.
- IDLE:
  - start_i=1 and cancel_i=0 at a rising edge: latch op, absolute values of the operands (signed ops only), and result sign flags. Load counter=WIDTH. Go to CALC.
  - DIV or DIVU with opb_i=0: set the dbz flag and go straight to DONE. No iterations run.
- CALC:
  - One iteration per cycle; counter decrements each cycle.
  - Multiply: shift-and-add of the unsigned magnitudes into a 2*WIDTH accumulator.
  - Divide: restoring divide, one quotient bit per cycle.
  - When counter reaches 1, apply sign correction on that same edge and go to DONE.
  - Sign correction: signed product is negated if the operand signs differ. Signed quotient is negated if the signs differ. Signed remainder takes the sign of the dividend.
- DONE:
  - done_o=1 and wrn_hilo_o=1 for exactly one cycle; hi_o and lo_o carry the results.
  - Next edge returns to IDLE. start_i is ignored in DONE.
- Result hold: hi_o and lo_o keep their last values until the next DONE. done_o and wrn_hilo_o are 0 outside DONE.
- stall_o (combinational):
  - 1 when state=CALC, or when state=IDLE with start_i=1 and cancel_i=0.
  - 0 in DONE, so EX consumes the result and the pipeline advances.
- Latency:
  - Normal op: done_o rises WIDTH+1 cycles after the accepting edge (33 for WIDTH=32).
  - Divide by zero: done_o rises 1 cycle after the accepting edge.
- Divide by zero: hi_o=0, lo_o=0, dbz_o=1.
- DIV of most-negative by -1: lo_o = most-negative (wraps), hi_o=0, dbz_o=0. No trap.
- cancel_i:
  - In CALC: next state IDLE. No done_o, no HI/LO write; hi_o and lo_o are unchanged.
  - In IDLE: blocks acceptance.
  - In DONE: ignored; the write still occurs.
  - cancel_i together with start_i in IDLE: nothing accepted.
- rst asserted mid-operation: immediate return to IDLE with all outputs at reset values. No done_o is ever produced for the aborted op.
- Unsigned ops (MULTU, DIVU): operands are used unmodified; no sign handling.

Test Plan:
- MULT opa=FFFFFFFD (-3), opb=00000007: done_o exactly 33 cycles after start. Expect hi_o=FFFFFFFF, lo_o=FFFFFFEB, wrn_hilo_o=1 for one cycle, stall_o=1 throughout CALC.
- MULTU FFFFFFFF × FFFFFFFF: expect hi_o=FFFFFFFE, lo_o=00000001. Then, with start_i still held through DONE, check that no second operation starts.
- DIV FFFFFFF9 (-7) / 00000002: expect lo_o=FFFFFFFD, hi_o=FFFFFFFF. Then DIVU 00000064 / 00000007: expect lo_o=0000000E, hi_o=00000002.
- DIV 80000000 / FFFFFFFF: expect lo_o=80000000, hi_o=00000000, dbz_o=0. Then DIVU 5 / 0: expect done_o 1 cycle after accept, dbz_o=1, hi_o=lo_o=0.
- Cancel and reset abort:
  - Start MULT, assert cancel_i on cycle 10 of CALC: expect IDLE next cycle, no done_o, hi_o/lo_o still hold the previous results.
  - Repeat, asserting rst asynchronously mid-CALC: expect all outputs 0 immediately.
  - Then a new DIVU 9/3 completes normally with lo_o=3, hi_o=0.

Source files
------------

// File: rtl/ex_muldiv_iter.sv
// ex_muldiv_iter: iterative multiply/divide unit beside the EX stage.
// Executes MULT, MULTU, DIV, DIVU on WIDTH-bit operands, one iteration per
// cycle, and delivers the HI/LO pair through the shared HI/LO write path.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start_i         request from EX (held while EX is stalled)
//   op_i            00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start_i)
//   opa_i, opb_i    rs (multiplicand / dividend), rt (multiplier / divisor)
//   cancel_i        pipeline flush; aborts an operation in CALC
//   stall_o         combinational stall request to pipeline control
//   done_o          one-cycle result-valid pulse
//   wrn_hilo_o      HI/LO write enable (same as done_o)
//   hi_o, lo_o      product high/low, or remainder/quotient
//   dbz_o           divide-by-zero flag, valid with done_o
module ex_muldiv_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             cancel_i,
  output logic             stall_o,
  output logic             done_o,
  output logic             wrn_hilo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             dbz_o
);

  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_neg_res;   // negate product / quotient
  logic             r_neg_rem;   // negate remainder (dividend sign)
  logic [WIDTH-1:0] r_a;         // multiplicand magnitude
  logic [WIDTH-1:0] r_b;         // divisor magnitude
  logic [W2-1:0]    r_acc;       // {high/remainder, low/multiplier-or-quotient}
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_dbz;
  logic             r_done;

  logic             w_accept;
  logic             w_dbz;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_trial;
  logic [W2-1:0]    w_acc_nxt;
  logic [W2-1:0]    w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_hi_fin;
  logic [WIDTH-1:0] w_lo_fin;

  // Request acceptance and operand preparation
  assign w_accept = (r_state == S_IDLE) && start_i && !cancel_i;
  assign w_dbz    = op_i[1] && (opb_i == '0);
  assign w_a_neg  = !op_i[0] && opa_i[WIDTH-1];
  assign w_b_neg  = !op_i[0] && opb_i[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (-opa_i) : opa_i;
  assign w_b_mag  = w_b_neg ? (-opb_i) : opb_i;

  // Stall while busy, and already in the accepting cycle so EX holds the op
  assign stall_o    = (r_state == S_CALC) || w_accept;
  assign done_o     = r_done;
  assign wrn_hilo_o = r_done;
  assign hi_o       = r_hi;
  assign lo_o       = r_lo;
  assign dbz_o      = r_dbz;

  // One iteration step: shift-and-add multiply or restoring divide
  always_comb begin
    w_acc_nxt = r_acc;
    w_add     = {1'b0, r_acc[W2-1:WIDTH]} + {1'b0, r_a};
    // Remainder shifted left with next dividend bit, minus divisor; the top
    // bit is the borrow (remainder < divisor keeps the difference in range)
    w_trial   = {r_acc[W2-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_b};
    if (r_is_div) begin
      if (!w_trial[WIDTH]) begin
        w_acc_nxt = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nxt = {r_acc[W2-2:0], 1'b0};
      end
    end else begin
      if (r_acc[0]) begin
        w_acc_nxt = {w_add, r_acc[WIDTH-1:1]};
      end else begin
        w_acc_nxt = {1'b0, r_acc[W2-1:1]};
      end
    end
  end

  // Sign correction applied to the final iteration's result
  always_comb begin
    w_prod   = r_neg_res ? (-w_acc_nxt) : w_acc_nxt;
    w_quo    = r_neg_res ? (-w_acc_nxt[WIDTH-1:0]) : w_acc_nxt[WIDTH-1:0];
    w_rem    = r_neg_rem ? (-w_acc_nxt[W2-1:WIDTH]) : w_acc_nxt[W2-1:WIDTH];
    w_hi_fin = r_is_div ? w_rem : w_prod[W2-1:WIDTH];
    w_lo_fin = r_is_div ? w_quo : w_prod[WIDTH-1:0];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_dbz ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (cancel_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_dbz     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_div  <= op_i[1];
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_a       <= w_a_mag;
            r_b       <= w_b_mag;
            r_acc     <= {{WIDTH{1'b0}}, (op_i[1] ? w_a_mag : w_b_mag)};
            r_cnt     <= CNT_W'(WIDTH);
            if (w_dbz) begin
              r_hi   <= '0;
              r_lo   <= '0;
              r_dbz  <= 1'b1;
              r_done <= 1'b1;
            end
          end
        end
        S_CALC: begin
          if (!cancel_i) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_hi   <= w_hi_fin;
              r_lo   <= w_lo_fin;
              r_dbz  <= 1'b0;
              r_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Directed testbench for ex_muldiv_iter (WIDTH=32).
module tb_ex_muldiv_iter;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] opa_i;
  logic [WIDTH-1:0] opb_i;
  logic             cancel_i;
  logic             stall_o;
  logic             done_o;
  logic             wrn_hilo_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             dbz_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Values captured by do_op
  int               lat;
  logic             ok_stall;
  logic             c_pre_stall;
  logic [WIDTH-1:0] c_hi;
  logic [WIDTH-1:0] c_lo;
  logic             c_dbz;
  logic             c_wrn;
  logic             c_stall;
  logic             p_stall;
  logic             p_done;
  int               pulses;

  ex_muldiv_iter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .opa_i      (opa_i),
    .opb_i      (opb_i),
    .cancel_i   (cancel_i),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .wrn_hilo_o (wrn_hilo_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .dbz_o      (dbz_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, hold start_i until done_o (bounded), capture the result.
  // Latency counts falling edges after the accepting edge up to done_o.
  task automatic do_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input bit hold);
    @(negedge clk);
    start_i = 1'b1;
    op_i    = op;
    opa_i   = a;
    opb_i   = b;
    #1 c_pre_stall = stall_o;
    @(posedge clk);
    lat      = 0;
    ok_stall = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!done_o) ok_stall = ok_stall & stall_o;
    end while (!done_o && lat < 80);
    c_hi    = hi_o;
    c_lo    = lo_o;
    c_dbz   = dbz_o;
    c_wrn   = wrn_hilo_o;
    c_stall = stall_o;
    if (hold) begin
      @(negedge clk);
      start_i = 1'b0;
      #1;
    end else begin
      start_i = 1'b0;
      @(negedge clk);
    end
    p_stall = stall_o;
    p_done  = done_o;
  endtask

  task automatic verify(input string t, input int exp_lat, input logic [WIDTH-1:0] e_hi,
                        input logic [WIDTH-1:0] e_lo, input logic e_dbz);
    chk({t, ".pre_stall"}, 64'(c_pre_stall), 64'd1);
    chk({t, ".latency"},   64'(lat),         64'(exp_lat));
    chk({t, ".calc_stall"},64'(ok_stall),    64'd1);
    chk({t, ".hi"},        64'(c_hi),        64'(e_hi));
    chk({t, ".lo"},        64'(c_lo),        64'(e_lo));
    chk({t, ".dbz"},       64'(c_dbz),       64'(e_dbz));
    chk({t, ".wrn"},       64'(c_wrn),       64'd1);
    chk({t, ".done_stall"},64'(c_stall),     64'd0);
    chk({t, ".post_done"}, 64'(p_done),      64'd0);
    chk({t, ".post_stall"},64'(p_stall),     64'd0);
  endtask

  task automatic check_zero_outputs(input string t);
    chk({t, ".done"},  64'(done_o),     64'd0);
    chk({t, ".wrn"},   64'(wrn_hilo_o), 64'd0);
    chk({t, ".hi"},    64'(hi_o),       64'd0);
    chk({t, ".lo"},    64'(lo_o),       64'd0);
    chk({t, ".dbz"},   64'(dbz_o),      64'd0);
    chk({t, ".stall"}, 64'(stall_o),    64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    start_i  = 1'b0;
    cancel_i = 1'b0;
    op_i     = 2'b00;
    opa_i    = '0;
    opb_i    = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    // MULT -3 * 7 = -21
    do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
    verify("mult_neg", 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

    // MULTU max*max, start_i held through DONE must not restart
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    verify("multu_max", 33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

    // DIV -7 / 2: quotient -3, remainder -1
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    verify("div_neg", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

    // DIVU 100 / 7: quotient 14, remainder 2
    do_op(2'b11, 32'h0000_0064, 32'h0000_0007, 1'b0);
    verify("divu", 33, 32'h0000_0002, 32'h0000_000E, 1'b0);

    // Cancel on cycle 10 of CALC: no write, previous results held
    @(negedge clk);
    start_i = 1'b1;
    op_i    = 2'b00;
    opa_i   = 32'h1234_5678;
    opb_i   = 32'h9ABC_DEF0;
    @(posedge clk);
    repeat (10) @(negedge clk);
    cancel_i = 1'b1;
    start_i  = 1'b0;
    @(negedge clk);
    cancel_i = 1'b0;
    #1;
    chk("cancel.stall", 64'(stall_o), 64'd0);
    chk("cancel.done",  64'(done_o),  64'd0);
    chk("cancel.hi",    64'(hi_o),    64'h0000_0002);
    chk("cancel.lo",    64'(lo_o),    64'h0000_000E);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o || wrn_hilo_o) pulses++;
    end
    chk("cancel.no_pulse", 64'(pulses), 64'd0);
    chk("cancel.hi_hold",  64'(hi_o),   64'h0000_0002);
    chk("cancel.lo_hold",  64'(lo_o),   64'h0000_000E);

    // DIV most-negative / -1 wraps, no trap
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    verify("div_ovf", 33, 32'h0000_0000, 32'h8000_0000, 1'b0);

    // Asynchronous reset mid-CALC clears every output at once
    @(negedge clk);
    start_i = 1'b1;
    op_i    = 2'b01;
    opa_i   = 32'h0000_0123;
    opb_i   = 32'h0000_0456;
    @(posedge clk);
    repeat (10) @(negedge clk);
    #3;
    rst     = 1'b1;
    start_i = 1'b0;
    #1;
    check_zero_outputs("rst_abort");
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o || wrn_hilo_o) pulses++;
    end
    chk("rst_abort.no_pulse", 64'(pulses), 64'd0);

    // DIVU 5 / 0: immediate DONE with dbz
    do_op(2'b11, 32'h0000_0005, 32'h0000_0000, 1'b0);
    verify("divu_dbz", 1, 32'h0000_0000, 32'h0000_0000, 1'b1);

    // DIVU 9 / 3 after abort completes normally
    do_op(2'b11, 32'h0000_0009, 32'h0000_0003, 1'b0);
    verify("divu_9_3", 33, 32'h0000_0000, 32'h0000_0003, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
